vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from a 25 MHz pixel clock.
- Outputs the free-running `HorizontalCounter`/`VerticalCounter` pair consumed by `coord_gen`, plus registered hsync, vsync, display-enable and frame/line strobes for the DAC/pin side.
- Drives the pixel pipeline: `vga_timing_gen` → `coord_gen` → character ROM → pins.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels); line total = 800
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines); frame total = 525
- `SYNC_NEG`, 1, 1 = hsync/vsync active-low
- `CTRL_DELAY`, 0, extra register stages on control outputs (0..7), matching downstream pixel-pipeline latency

Ports (one clock; reset is asynchronous and active-low):
- `clock25`  in  1  pixel clock, 25 MHz
- `reset_n`  in  1  asynchronous active-low reset
- `enable`  in  1  count enable; low freezes all state
- `HorizontalCounter`  out  10  pixel index in line, 0..799
- `VerticalCounter`  out  10  line index in frame, 0..524
- `hsync`  out  1  horizontal sync, polarity per `SYNC_NEG`
- `vsync`  out  1  vertical sync, polarity per `SYNC_NEG`
- `de`  out  1  display enable, high in the 640x480 active region
- `lineStart`  out  1  one-cycle pulse at H=0
- `frameStart`  out  1  one-cycle pulse at H=0, V=0
- `frameCount`  out  8  frame counter, wraps 255→0

## Operation
- **Horizontal counter:** on each `clock25` edge with `enable`=1, `HorizontalCounter` increments; at 799 it wraps to 0.
- **Vertical counter:** increments only on that horizontal wrap; at 524 it wraps to 0.
- **Frame count:** `frameCount` increments when both counters wrap together (799,524 → 0,0).
- **Decode:** combinational from the counter registers, then registered in stage 0:
  - de = H<640 && V<480
  - hsync asserted for H in 656..751
  - vsync asserted for V in 490..491 (whole lines)
  - lineStart = H==0
  - frameStart = H==0 && V==0
- **Sync polarity:** asserted level = !`SYNC_NEG`.
- **Control delay:** control outputs then pass through `CTRL_DELAY` further registers. Counters are never delayed.
- **`enable` low:** counters, `frameCount` and every control pipeline stage hold their values. Strobes are not re-issued while frozen; a strobe present at freeze stays visible until `enable` returns. Resumption continues with no lost or duplicated pixel.
- **Width rule:** counters compare against parameter sums computed in 10 bits; parameters must satisfy totals ≤ 1024.

## Timing
- **Reset (asynchronous):** counters = 0; `frameCount` = 0; de = 0; lineStart = 0; frameStart = 0; hsync and vsync at deasserted level (1 when `SYNC_NEG`=1). All delay stages clear to the same values.
- **First edge after reset release** with `enable`=1:
  - counters → (1,0)
  - stage 0 captures the decode of (0,0): de = 1, lineStart = 1, frameStart = 1
- **Latency:** control outputs correspond to counter value (H,V) exactly `1+CTRL_DELAY` enabled cycles after the counters showed (H,V).
- **hsync:** low for 96 consecutive cycles per line; period 800 cycles.
- **vsync:** low for 1600 consecutive cycles; period 420000 cycles.
- **Reset mid-frame:** immediate return to reset state; no partial sync pulse is extended.

## Structure
- Shared package `vga_pkg`:
  - 640x480 timing constants
  - derived totals (`H_TOTAL`, `V_TOTAL`) and sync start/end values
  - counter width (10)
  - `coord_gen` reuses these constants
- One sub-module, `vga_delay_line`: parameterised width/depth register chain with enable and async active-low reset. Used for the control bundle (5 bits).

## Test plan
- **Reset release:** reset then release, `enable`=1, default params → after 1 edge H=1, V=0, de=1, frameStart=1; after 2 edges frameStart=0.
- **Horizontal sync and line wrap:** run 800 cycles →
  - hsync=0 exactly while the registered decode reflects H 656..751
  - de=0 for H≥640
  - H wraps 799→0 with V 0→1
- **Full frame:** run 420000 cycles →
  - vsync low exactly 1600 cycles, during lines 490–491
  - exactly one frameStart
  - counters (0,0) at end, `frameCount`=1
- **Enable freeze:** hold `enable`=0 for 37 cycles at H=655 → no output changes; after re-enable hsync asserts on schedule and the line still totals 800 enabled cycles.
- **Delay and polarity:** `CTRL_DELAY`=3, `SYNC_NEG`=0 → hsync high, and de/frameStart trail the counters by exactly 4 cycles.
- **Async reset mid-frame:** assert `reset_n` at H=700, V=491, between clock edges → all outputs at reset values before the next `clock25` edge; vsync/hsync deasserted.

Source files
------------

// File: rtl/vga_pkg.sv
//==============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing constants, control bundle type and
//               sync polarity helper for the VGA raster pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC - 1;
    localparam int V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC - 1;

    typedef struct packed {
        logic frameStart;
        logic lineStart;
        logic vsync;
        logic hsync;
        logic de;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Pin level for a sync pulse given its logical state and polarity.
    function automatic logic syncLevel(input logic active, input logic neg);
        return active ^ neg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
//==============================================================================
// Module      : vga_delay_line
// Description : Parameterised WIDTH x DEPTH register chain with enable and
//               asynchronous active-low reset to a configurable value.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int               WIDTH   = 5,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH*WIDTH-1:0] r_chain;
    logic [DEPTH*WIDTH-1:0] w_next;

    // Newest sample enters at the low end; the oldest leaves from the top.
    if (DEPTH == 1) begin : g_single
        assign w_next = din;
    end else begin : g_multi
        assign w_next = {r_chain[(DEPTH-1)*WIDTH-1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {DEPTH{RST_VAL}};
        end else if (en) begin
            r_chain <= w_next;
        end
    end

    assign dout = r_chain[DEPTH*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator: free-running H/V counters, frame
//               counter and registered, optionally delayed sync/enable strobes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int SYNC_NEG   = 1,
    parameter int CTRL_DELAY = 0
) (
    input  logic             clock25,
    input  logic             reset_n,
    input  logic             enable,
    output logic [CNT_W-1:0] HorizontalCounter,
    output logic [CNT_W-1:0] VerticalCounter,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             lineStart,
    output logic             frameStart,
    output logic [7:0]       frameCount
);

    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_hActive   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_vActive   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_hLast     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_vLast     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] c_hSyncBeg  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hSyncEnd  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_vSyncBeg  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vSyncEnd  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             c_syncNeg   = (SYNC_NEG != 0);
    localparam ctrl_t            c_ctrlRst   = '{frameStart: 1'b0, lineStart: 1'b0,
                                                 vsync: c_syncNeg, hsync: c_syncNeg,
                                                 de: 1'b0};

    logic [CNT_W-1:0] r_hCount;
    logic [CNT_W-1:0] r_vCount;
    logic [7:0]       r_frameCount;
    ctrl_t            w_ctrlIn;
    ctrl_t            w_ctrlOut;

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            r_hCount     <= '0;
            r_vCount     <= '0;
            r_frameCount <= '0;
        end else if (enable) begin
            if (r_hCount == c_hLast) begin
                r_hCount <= '0;
                if (r_vCount == c_vLast) begin
                    r_vCount     <= '0;
                    r_frameCount <= r_frameCount + 8'd1;
                end else begin
                    r_vCount <= r_vCount + c_one;
                end
            end else begin
                r_hCount <= r_hCount + c_one;
            end
        end
    end

    // Decode of the current counter pair; the delay line's first stage registers it.
    always_comb begin
        w_ctrlIn.de         = (r_hCount < c_hActive) && (r_vCount < c_vActive);
        w_ctrlIn.hsync      = syncLevel((r_hCount >= c_hSyncBeg) && (r_hCount <= c_hSyncEnd),
                                        c_syncNeg);
        w_ctrlIn.vsync      = syncLevel((r_vCount >= c_vSyncBeg) && (r_vCount <= c_vSyncEnd),
                                        c_syncNeg);
        w_ctrlIn.lineStart  = (r_hCount == '0);
        w_ctrlIn.frameStart = (r_hCount == '0) && (r_vCount == '0);
    end

    vga_delay_line #(
        .WIDTH   (CTRL_W),
        .DEPTH   (CTRL_DELAY + 1),
        .RST_VAL (c_ctrlRst)
    ) u_ctrlDelay (
        .clk   (clock25),
        .rst_n (reset_n),
        .en    (enable),
        .din   (w_ctrlIn),
        .dout  (w_ctrlOut)
    );

    assign HorizontalCounter = r_hCount;
    assign VerticalCounter   = r_vCount;
    assign frameCount        = r_frameCount;
    assign hsync             = w_ctrlOut.hsync;
    assign vsync             = w_ctrlOut.vsync;
    assign de                = w_ctrlOut.de;
    assign lineStart         = w_ctrlOut.lineStart;
    assign frameStart        = w_ctrlOut.frameStart;

endmodule

`default_nettype wire
